// File: rtl/decode_issue_stage.sv
// decode_issue_stage: one-entry registered decode/issue stage for RV32I.
// Decodes a fetched instruction, resolves its operands from the regfile, the ROB or the
// result broadcast channels, holds it while the ROB or the target unit is full (snooping
// broadcasts meanwhile) and issues it as soon as space frees up.
// Optional build macro: DECODE_ILLEGAL_CHECK_EN -- opcodes outside RV32I are consumed
// without issuing and reported on illegal_inst / illegal_pc.
module decode_issue_stage #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_POS_W = 5,
   parameter int unsigned ROB_POS_W = 4,
   parameter int unsigned NUM_CDB   = 2,
   parameter int unsigned ROB_ID_W  = ROB_POS_W + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic                          rollback,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [31:0]                   inst,
   input  logic [DATA_W-1:0]             inst_pc,
   input  logic                          inst_pred_jump,
   output logic [REG_POS_W-1:0]          reg_rs1,
   output logic [REG_POS_W-1:0]          reg_rs2,
   input  logic [DATA_W-1:0]             reg_rs1_val,
   input  logic [DATA_W-1:0]             reg_rs2_val,
   input  logic [ROB_ID_W-1:0]           reg_rs1_rob_id,
   input  logic [ROB_ID_W-1:0]           reg_rs2_rob_id,
   output logic [ROB_POS_W-1:0]          rob_rs1_pos,
   output logic [ROB_POS_W-1:0]          rob_rs2_pos,
   input  logic                          rob_rs1_ready,
   input  logic                          rob_rs2_ready,
   input  logic [DATA_W-1:0]             rob_rs1_val,
   input  logic [DATA_W-1:0]             rob_rs2_val,
   input  logic [ROB_POS_W-1:0]          nxt_rob_pos,
   input  logic                          rob_full,
   input  logic                          rs_full,
   input  logic                          lsb_full,
   input  logic [NUM_CDB-1:0]            cdb_valid,
   input  logic [NUM_CDB*ROB_POS_W-1:0]  cdb_rob_pos,
   input  logic [NUM_CDB*DATA_W-1:0]     cdb_val,
   output logic                          issue,
   output logic                          rs_en,
   output logic                          lsb_en,
   output logic [ROB_POS_W-1:0]          rob_pos,
   output logic [6:0]                    opcode,
   output logic [2:0]                    funct3,
   output logic                          funct7,
   output logic [DATA_W-1:0]             rs1_val,
   output logic [DATA_W-1:0]             rs2_val,
   output logic [ROB_ID_W-1:0]           rs1_rob_id,
   output logic [ROB_ID_W-1:0]           rs2_rob_id,
   output logic [DATA_W-1:0]             imm,
   output logic [REG_POS_W-1:0]          rd,
   output logic [DATA_W-1:0]             pc,
   output logic                          pred_jump,
   output logic                          is_ready
`ifdef DECODE_ILLEGAL_CHECK_EN
   ,
   output logic                          illegal_inst,
   output logic [DATA_W-1:0]             illegal_pc
`endif
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpArithI = 7'b0010011;
   localparam logic [6:0] OpArith  = 7'b0110011;

   typedef enum logic {StEmpty, StHeld} state_e;

   state_e state_q, state_d;
   logic   held, capture, can_go, drop, issuable;

   // Held instruction
   logic                 rs_en_q, lsb_en_q, funct7_q, pred_q, is_ready_q;
   logic [6:0]           opcode_q;
   logic [2:0]           funct3_q;
   logic [DATA_W-1:0]    rs1_val_q, rs2_val_q, imm_q, pc_q;
   logic [ROB_ID_W-1:0]  rs1_id_q, rs2_id_q;
   logic [REG_POS_W-1:0] rd_q;

   // Decode of the offered instruction
   logic                 dec_rs_en, dec_lsb_en, dec_mask1, dec_mask2, dec_is_ready;
   logic [31:0]          dec_imm;
   logic [REG_POS_W-1:0] dec_rd;
   logic                 bypass1, bypass2;
   logic [ROB_ID_W+DATA_W-1:0] res1, res2;
   logic [DATA_W:0]      cap_cdb1, cap_cdb2, fwd1, fwd2;
   logic                 hit1, hit2;

   // Broadcast match for a tag; {hit, value}. Lowest channel index wins.
   function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_ID_W-1:0] tag,
                                                  input logic [NUM_CDB-1:0] valid,
                                                  input logic [NUM_CDB*ROB_POS_W-1:0] pos,
                                                  input logic [NUM_CDB*DATA_W-1:0] val);
      logic [DATA_W:0] res;
      res = '0;
      for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
         if (tag[ROB_ID_W-1] && valid[i] &&
             pos[i*ROB_POS_W +: ROB_POS_W] == tag[ROB_POS_W-1:0]) begin
            res = {1'b1, val[i*DATA_W +: DATA_W]};
         end
      end
      return res;
   endfunction

   // Operand at capture; {rob_id, value}, rob_id 0 means value is final.
   function automatic logic [ROB_ID_W+DATA_W-1:0] resolve(input logic masked,
                                                          input logic bypass,
                                                          input logic [ROB_POS_W-1:0] byp_pos,
                                                          input logic [ROB_ID_W-1:0] tag,
                                                          input logic [DATA_W-1:0] reg_val,
                                                          input logic rob_ready,
                                                          input logic [DATA_W-1:0] rob_val,
                                                          input logic [DATA_W:0] cdb);
      if (masked) return '0;
      if (bypass) return {1'b1, byp_pos, {DATA_W{1'b0}}};
      if (!tag[ROB_ID_W-1]) return {{ROB_ID_W{1'b0}}, reg_val};
      if (rob_ready) return {{ROB_ID_W{1'b0}}, rob_val};
      if (cdb[DATA_W]) return {{ROB_ID_W{1'b0}}, cdb[DATA_W-1:0]};
      return {tag, {DATA_W{1'b0}}};
   endfunction

   assign held        = (state_q == StHeld);
   assign reg_rs1     = REG_POS_W'(inst[19:15]);
   assign reg_rs2     = REG_POS_W'(inst[24:20]);
   assign rob_rs1_pos = reg_rs1_rob_id[ROB_POS_W-1:0];
   assign rob_rs2_pos = reg_rs2_rob_id[ROB_POS_W-1:0];

`ifdef DECODE_ILLEGAL_CHECK_EN
   logic illegal_q, dec_known;
   assign issuable     = ~illegal_q;
   assign drop         = ~rst & held & illegal_q & rdy & ~rollback;
   assign illegal_inst = drop;
   assign illegal_pc   = pc_q;
`else
   assign issuable = 1'b1;
   assign drop     = 1'b0;
`endif

   // Field decode and immediate selection per opcode class
   always_comb begin
      dec_rs_en    = 1'b0;
      dec_lsb_en   = 1'b0;
      dec_mask1    = 1'b1;
      dec_mask2    = 1'b1;
      dec_is_ready = 1'b0;
      dec_imm      = '0;
      dec_rd       = REG_POS_W'(inst[11:7]);
`ifdef DECODE_ILLEGAL_CHECK_EN
      dec_known    = 1'b1;
`endif
      case (inst[6:0])
         OpStore: begin
            dec_lsb_en   = 1'b1;
            dec_mask1    = 1'b0;
            dec_mask2    = 1'b0;
            dec_rd       = '0;
            dec_is_ready = 1'b1;
            dec_imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         OpLoad: begin
            dec_lsb_en = 1'b1;
            dec_mask1  = 1'b0;
            dec_imm    = {{20{inst[31]}}, inst[31:20]};
         end
         OpArithI, OpJalr: begin
            dec_rs_en = 1'b1;
            dec_mask1 = 1'b0;
            dec_imm   = {{20{inst[31]}}, inst[31:20]};
         end
         OpArith: begin
            dec_rs_en = 1'b1;
            dec_mask1 = 1'b0;
            dec_mask2 = 1'b0;
         end
         OpJal: begin
            dec_rs_en = 1'b1;
            dec_imm   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OpBranch: begin
            dec_rs_en = 1'b1;
            dec_mask1 = 1'b0;
            dec_mask2 = 1'b0;
            dec_rd    = '0;
            dec_imm   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OpLui, OpAuipc: begin
            dec_rs_en = 1'b1;
            dec_imm   = {inst[31:12], 12'b0};
         end
         default: begin
`ifdef DECODE_ILLEGAL_CHECK_EN
            dec_known = 1'b0;
`endif
         end
      endcase
   end

   // Operand resolution at capture, including the RAW bypass against the issuing inst
   always_comb begin
      bypass1  = issue && (rd_q != '0) && (rd_q == reg_rs1);
      bypass2  = issue && (rd_q != '0) && (rd_q == reg_rs2);
      cap_cdb1 = cdb_lookup(reg_rs1_rob_id, cdb_valid, cdb_rob_pos, cdb_val);
      cap_cdb2 = cdb_lookup(reg_rs2_rob_id, cdb_valid, cdb_rob_pos, cdb_val);
      res1     = resolve(dec_mask1, bypass1, nxt_rob_pos, reg_rs1_rob_id, reg_rs1_val,
                         rob_rs1_ready, rob_rs1_val, cap_cdb1);
      res2     = resolve(dec_mask2, bypass2, nxt_rob_pos, reg_rs2_rob_id, reg_rs2_val,
                         rob_rs2_ready, rob_rs2_val, cap_cdb2);
      // Snoop of held pending operands; also forwarded straight to the outputs
      fwd1     = cdb_lookup(rs1_id_q, cdb_valid, cdb_rob_pos, cdb_val);
      fwd2     = cdb_lookup(rs2_id_q, cdb_valid, cdb_rob_pos, cdb_val);
      hit1     = rdy & fwd1[DATA_W];
      hit2     = rdy & fwd2[DATA_W];
   end

   // Stage occupancy register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StEmpty;
      else     state_q <= state_d;
   end

   // Handshake, issue decision and next occupancy
   always_comb begin
      state_d  = state_q;
      can_go   = ~rst & held & issuable & rdy & ~rollback & ~rob_full &
                 ~(rs_en_q & rs_full) & ~(lsb_en_q & lsb_full);
      issue    = can_go;
      in_ready = ~rst & rdy & ~rollback & (~held | can_go | drop);
      capture  = in_valid & in_ready;
      if (rollback)                state_d = StEmpty;
      else if (capture)            state_d = StHeld;
      else if (can_go || drop)     state_d = StEmpty;
   end

   // Holding register: load on capture, otherwise absorb matching broadcasts
   always_ff @(posedge clk) begin
      if (rst) begin
         rs_en_q    <= 1'b0;
         lsb_en_q   <= 1'b0;
         opcode_q   <= '0;
         funct3_q   <= '0;
         funct7_q   <= 1'b0;
         rs1_val_q  <= '0;
         rs2_val_q  <= '0;
         rs1_id_q   <= '0;
         rs2_id_q   <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         pc_q       <= '0;
         pred_q     <= 1'b0;
         is_ready_q <= 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
         illegal_q  <= 1'b0;
`endif
      end else if (capture) begin
         rs_en_q    <= dec_rs_en;
         lsb_en_q   <= dec_lsb_en;
         opcode_q   <= inst[6:0];
         funct3_q   <= inst[14:12];
         funct7_q   <= inst[30];
         rs1_val_q  <= res1[DATA_W-1:0];
         rs1_id_q   <= res1[ROB_ID_W+DATA_W-1:DATA_W];
         rs2_val_q  <= res2[DATA_W-1:0];
         rs2_id_q   <= res2[ROB_ID_W+DATA_W-1:DATA_W];
         imm_q      <= DATA_W'($signed(dec_imm));
         rd_q       <= dec_rd;
         pc_q       <= inst_pc;
         pred_q     <= inst_pred_jump;
         is_ready_q <= dec_is_ready;
`ifdef DECODE_ILLEGAL_CHECK_EN
         illegal_q  <= ~dec_known;
`endif
      end else if (held) begin
         if (hit1) begin
            rs1_val_q <= fwd1[DATA_W-1:0];
            rs1_id_q  <= '0;
         end
         if (hit2) begin
            rs2_val_q <= fwd2[DATA_W-1:0];
            rs2_id_q  <= '0;
         end
      end
   end

   assign rs_en      = issue & rs_en_q;
   assign lsb_en     = issue & lsb_en_q;
   assign rob_pos    = issue ? nxt_rob_pos : '0;
   assign opcode     = opcode_q;
   assign funct3     = funct3_q;
   assign funct7     = funct7_q;
   assign rs1_val    = hit1 ? fwd1[DATA_W-1:0] : rs1_val_q;
   assign rs2_val    = hit2 ? fwd2[DATA_W-1:0] : rs2_val_q;
   assign rs1_rob_id = hit1 ? '0 : rs1_id_q;
   assign rs2_rob_id = hit2 ? '0 : rs2_id_q;
   assign imm        = imm_q;
   assign rd         = rd_q;
   assign pc         = pc_q;
   assign pred_jump  = pred_q;
   assign is_ready   = is_ready_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed vector table for single decodes plus hand-written
// multi-cycle sequences (back-pressure, CDB snoop, RAW bypass, rollback, freeze).
module tb_decode_issue_stage;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, in_valid, in_ready;
   logic [31:0] inst, inst_pc;
   logic        inst_pred_jump;
   logic [4:0]  reg_rs1, reg_rs2;
   logic [31:0] reg_rs1_val, reg_rs2_val;
   logic [4:0]  reg_rs1_rob_id, reg_rs2_rob_id;
   logic [3:0]  rob_rs1_pos, rob_rs2_pos;
   logic        rob_rs1_ready, rob_rs2_ready;
   logic [31:0] rob_rs1_val, rob_rs2_val;
   logic [3:0]  nxt_rob_pos;
   logic        rob_full, rs_full, lsb_full;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_rob_pos;
   logic [63:0] cdb_val;
   logic        issue, rs_en, lsb_en;
   logic [3:0]  rob_pos;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rs1_rob_id, rs2_rob_id;
   logic [31:0] imm;
   logic [4:0]  rd;
   logic [31:0] pc;
   logic        pred_jump, is_ready;
`ifdef DECODE_ILLEGAL_CHECK_EN
   logic        illegal_inst;
   logic [31:0] illegal_pc;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_issue_stage dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .inst_pc(inst_pc), .inst_pred_jump(inst_pred_jump),
      .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
      .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
      .reg_rs1_rob_id(reg_rs1_rob_id), .reg_rs2_rob_id(reg_rs2_rob_id),
      .rob_rs1_pos(rob_rs1_pos), .rob_rs2_pos(rob_rs2_pos),
      .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
      .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
      .nxt_rob_pos(nxt_rob_pos),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
      .issue(issue), .rs_en(rs_en), .lsb_en(lsb_en), .rob_pos(rob_pos),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
      .imm(imm), .rd(rd), .pc(pc), .pred_jump(pred_jump), .is_ready(is_ready)
`ifdef DECODE_ILLEGAL_CHECK_EN
      , .illegal_inst(illegal_inst), .illegal_pc(illegal_pc)
`endif
   );

   typedef struct {
      logic [31:0] inst, pc;
      logic [31:0] v1;  logic [4:0] t1;
      logic [31:0] v2;  logic [4:0] t2;
      logic        r1rdy; logic [31:0] r1val;
      logic        r2rdy; logic [31:0] r2val;
      logic [1:0]  cv; logic [7:0] cpos; logic [63:0] cval;
      logic        e_rs, e_lsb;
      logic [31:0] e_imm; logic [4:0] e_rd;
      logic [31:0] e_v1; logic [4:0] e_id1;
      logic [31:0] e_v2; logic [4:0] e_id2;
      logic        e_isr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] i_inst, input logic [31:0] i_pc,
                      input logic [31:0] v1, input logic [4:0] t1,
                      input logic [31:0] v2, input logic [4:0] t2,
                      input logic r1rdy, input logic [31:0] r1val,
                      input logic r2rdy, input logic [31:0] r2val,
                      input logic [1:0] cv, input logic [7:0] cpos, input logic [63:0] cval,
                      input logic e_rs, input logic e_lsb, input logic [31:0] e_imm,
                      input logic [4:0] e_rd, input logic [31:0] e_v1, input logic [4:0] e_id1,
                      input logic [31:0] e_v2, input logic [4:0] e_id2, input logic e_isr);
      vec_t v;
      v.inst = i_inst; v.pc = i_pc; v.v1 = v1; v.t1 = t1; v.v2 = v2; v.t2 = t2;
      v.r1rdy = r1rdy; v.r1val = r1val; v.r2rdy = r2rdy; v.r2val = r2val;
      v.cv = cv; v.cpos = cpos; v.cval = cval;
      v.e_rs = e_rs; v.e_lsb = e_lsb; v.e_imm = e_imm; v.e_rd = e_rd;
      v.e_v1 = e_v1; v.e_id1 = e_id1; v.e_v2 = e_v2; v.e_id2 = e_id2; v.e_isr = e_isr;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      rollback = 0; in_valid = 0; inst = 0; inst_pc = 0; inst_pred_jump = 0;
      reg_rs1_val = 0; reg_rs2_val = 0; reg_rs1_rob_id = 0; reg_rs2_rob_id = 0;
      rob_rs1_ready = 0; rob_rs2_ready = 0; rob_rs1_val = 0; rob_rs2_val = 0;
      nxt_rob_pos = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
      cdb_valid = 0; cdb_rob_pos = 0; cdb_val = 0;
   endtask

   initial begin
      // inst, pc, v1,t1, v2,t2, rob1, rob2, cdb, rs,lsb, imm, rd, e_v1,id1, e_v2,id2, is_ready
      add(32'h00500093, 32'h1000, 0, 0, 32'h777, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 32'd5, 5'd1, 0, 0, 0, 0, 0);                                       // ADDI
      add(32'h002081B3, 32'h1004, 32'h11, 0, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 0, 5'd3, 32'h11, 0, 32'h22, 0, 0);                                 // ADD
      add(32'h402081B3, 32'h1008, 32'h11, 5'h12, 32'h22, 5'h13, 1, 32'hAA, 0, 32'hBB,
          0, 0, 0, 1, 0, 0, 5'd3, 32'hAA, 0, 0, 5'h13, 0);                         // SUB, ROB
      add(32'h00512423, 32'h100C, 32'h100, 0, 32'h5, 5'h14, 0, 0, 0, 0,
          2'b11, 8'h44, {32'h98, 32'h99},
          0, 1, 32'd8, 5'd0, 32'h100, 0, 32'h99, 0, 1);                            // SW, CDB
      add(32'hFFC12303, 32'h1010, 32'h200, 0, 32'h333, 5'h1F, 0, 0, 0, 0, 0, 0, 0,
          0, 1, 32'hFFFFFFFC, 5'd6, 32'h200, 0, 0, 0, 0);                          // LW
      add(32'h00208863, 32'h1014, 32'h1, 0, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 32'd16, 5'd0, 32'h1, 0, 32'h2, 0, 0);                              // BEQ
      add(32'h123453B7, 32'h1018, 32'hA, 0, 32'hB, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 32'h12345000, 5'd7, 0, 0, 0, 0, 0);                                // LUI
      add(32'hFFFFF0EF, 32'h101C, 32'hA, 0, 32'hB, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 32'hFFFFFFFE, 5'd1, 0, 0, 0, 0, 0);                                // JAL
      add(32'h00008067, 32'h1020, 32'hC, 5'h15, 32'hD, 0, 0, 0, 0, 0,
          2'b11, 8'h56, {32'h1234, 32'h9999},
          1, 0, 0, 5'd0, 32'h1234, 0, 0, 0, 0);                                    // JALR, CDB1
      add(32'h00001117, 32'h1024, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 32'h1000, 5'd2, 0, 0, 0, 0, 0);                                    // AUIPC
      add(32'h002081B3, 32'h1028, 32'hE, 5'h19, 32'h44, 0, 0, 0, 0, 0,
          2'b01, 8'h08, {32'h0, 32'h5}, 1, 0, 0, 5'd3, 0, 5'h19, 32'h44, 0, 0);   // pending
      add(32'hFFF18213, 32'h102C, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 32'hFFFFFFFF, 5'd4, 32'h7, 0, 0, 0, 0);                            // ADDI -1

      clear_inputs();
      rst = 1; rdy = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_outs", {issue, rs_en, lsb_en, rob_pos, rs1_val, rs1_rob_id, rs2_val, imm, rd, pc,
                         is_ready}, '0);
      rst = 0;
      #1;
      check("idle", {issue, in_ready}, 2'b01);

      // Single-instruction vectors: capture, then issue the following cycle
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         inst = v.inst; inst_pc = v.pc; inst_pred_jump = i[0];
         reg_rs1_val = v.v1; reg_rs1_rob_id = v.t1; reg_rs2_val = v.v2; reg_rs2_rob_id = v.t2;
         rob_rs1_ready = v.r1rdy; rob_rs1_val = v.r1val;
         rob_rs2_ready = v.r2rdy; rob_rs2_val = v.r2val;
         cdb_valid = v.cv; cdb_rob_pos = v.cpos; cdb_val = v.cval;
         nxt_rob_pos = 4'd9; in_valid = 1;
         #1;
         check($sformatf("v%0d_query", i), {in_ready, issue, reg_rs1, reg_rs2, rob_rs1_pos,
               rob_rs2_pos}, {2'b10, v.inst[19:15], v.inst[24:20], v.t1[3:0], v.t2[3:0]});
         step();
         in_valid = 0; cdb_valid = 0; rob_rs1_ready = 0; rob_rs2_ready = 0;
         #1;
         check($sformatf("v%0d_ctl", i), {issue, rs_en, lsb_en, rob_pos, is_ready, rd, pred_jump},
               {1'b1, v.e_rs, v.e_lsb, 4'd9, v.e_isr, v.e_rd, i[0]});
         check($sformatf("v%0d_fields", i), {opcode, funct3, funct7, imm, pc},
               {v.inst[6:0], v.inst[14:12], v.inst[30], v.e_imm, v.pc});
         check($sformatf("v%0d_ops", i), {rs1_val, rs1_rob_id, rs2_val, rs2_rob_id},
               {v.e_v1, v.e_id1, v.e_v2, v.e_id2});
         step();
      end
      clear_inputs();

      // RS full for 3 cycles, pending rs1 resolved by channel 1 while waiting
      inst = 32'h002081B3; inst_pc = 32'h2000; reg_rs1_rob_id = 5'h13; reg_rs1_val = 32'hDEAD;
      reg_rs2_val = 32'h22; rs_full = 1; in_valid = 1;
      #1; step();
      in_valid = 0;
      #1;
      check("s2_c1", {issue, rs1_rob_id}, {1'b0, 5'h13});
      step();
      cdb_valid = 2'b10; cdb_rob_pos = 8'h30; cdb_val = {32'h55, 32'h0};
      #1;
      check("s2_c2", {issue, rs1_val, rs1_rob_id}, {1'b0, 32'h55, 5'h0});
      step();
      cdb_valid = 0;
      #1;
      check("s2_c3", {issue, in_ready, rs1_val, rs1_rob_id}, {2'b00, 32'h55, 5'h0});
      step();
      rs_full = 0;
      #1;
      check("s2_issue", {issue, rs_en, rs1_val, rs1_rob_id, rs2_val, rs2_rob_id},
            {2'b11, 32'h55, 5'h0, 32'h22, 5'h0});
      step();
      clear_inputs();

      // Back-to-back RAW: ADDI x1 then ADD x2,x1,x1 with a stale regfile tag
      inst = 32'h00500093; in_valid = 1;
      #1; step();
      inst = 32'h00108133; reg_rs1_val = 32'h77; reg_rs2_val = 32'h77; nxt_rob_pos = 4'd6;
      #1;
      check("s3_overlap", {issue, in_ready, rob_pos, rd}, {2'b11, 4'd6, 5'd1});
      step();
      in_valid = 0; nxt_rob_pos = 4'd7;
      #1;
      check("s3_bypass", {issue, rs1_val, rs1_rob_id, rs2_val, rs2_rob_id, rob_pos, rd},
            {1'b1, 32'h0, 5'h16, 32'h0, 5'h16, 4'd7, 5'd2});
      step();
      clear_inputs();

      // Load held by a full LSB, then flushed
      inst = 32'h00012303; lsb_full = 1; in_valid = 1;
      #1; step();
      in_valid = 0;
      #1;
      check("s4_blocked", {issue, in_ready}, 2'b00);
      step();
      rollback = 1; in_valid = 1; inst = 32'h00500093;
      #1;
      check("s4_rollback", {issue, in_ready}, 2'b00);
      step();
      rollback = 0; in_valid = 0; lsb_full = 0;
      #1;
      check("s4_flushed", {issue, in_ready}, 2'b01);
      step();
      clear_inputs();

      // Both channels hit the same tag; channel 0 wins. rs2 forwarded at issue
      inst = 32'h002081B3; reg_rs1_rob_id = 5'h12; reg_rs2_rob_id = 5'h1A;
      reg_rs1_val = 32'hBAD; reg_rs2_val = 32'hBAD; rob_full = 1; in_valid = 1;
      #1; step();
      in_valid = 0; cdb_valid = 2'b11; cdb_rob_pos = 8'h22; cdb_val = {32'h2, 32'h1};
      #1;
      check("s5_dual_cdb", {issue, rs1_val, rs1_rob_id, rs2_rob_id}, {1'b0, 32'h1, 5'h0, 5'h1A});
      step();
      rob_full = 0; cdb_valid = 2'b10; cdb_rob_pos = 8'hA0; cdb_val = {32'h3C, 32'h0};
      #1;
      check("s5_issue_fwd", {issue, rs1_val, rs1_rob_id, rs2_val, rs2_rob_id},
            {1'b1, 32'h1, 5'h0, 32'h3C, 5'h0});
      step();
      clear_inputs();

      // rdy low freezes the held instruction and blocks new capture
      inst = 32'h00500093; in_valid = 1;
      #1; step();
      inst = 32'h00A00113; rdy = 0;
      #1;
      check("frz_hold", {issue, in_ready}, 2'b00);
      step();
      rdy = 1; in_valid = 0;
      #1;
      check("frz_release", {issue, imm, rd}, {1'b1, 32'd5, 5'd1});
      step();
      clear_inputs();

`ifdef DECODE_ILLEGAL_CHECK_EN
      inst = 32'hFFFFFFFF; inst_pc = 32'h40; in_valid = 1;
      #1; step();
      in_valid = 0;
      #1;
      check("ill_pulse", {issue, illegal_inst, illegal_pc}, {2'b01, 32'h40});
      step();
      check("ill_gone", {issue, illegal_inst, in_ready}, 3'b001);
`else
      inst = 32'h0000007F; in_valid = 1;
      #1; step();
      in_valid = 0;
      #1;
      check("unknown_op", {issue, rs_en, lsb_en, opcode}, {3'b100, 7'h7F});
      step();
      check("unknown_done", {issue, in_ready}, 2'b01);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
